// File: rtl/wb_regfile_pkg.sv
// Shared constants for the write-back stage and register file.
// The optional same-cycle bypass is enabled by defining WB_REGFILE_BYPASS_EN.
package wb_regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_REG   = 0;

  localparam logic WB_SRC_ALU = 1'b0;
  localparam logic WB_SRC_MEM = 1'b1;
endpackage

// File: rtl/wb_regfile_wb_mux.sv
// Write-back source select and effective write-enable generation.
// Kept standalone so the forwarding unit's model can instantiate the same logic.
module wb_mux
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              i_reg_wr,
  input  logic              i_wrback,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic [ADDR_W-1:0] i_write_reg,
  output logic [DATA_W-1:0] o_wb_data,
  output logic              o_wb_we
);
  assign o_wb_data = (i_wrback == WB_SRC_MEM) ? i_mem_data : i_alu_result;
  // Writes aimed at the zero register are suppressed here so no consumer sees them
  assign o_wb_we   = i_reg_wr && (i_write_reg != ADDR_W'(ZERO_REG));
endmodule

// File: rtl/wb_regfile.sv
// MIPS write-back stage plus 2^ADDR_W x DATA_W register file with two async read ports.
// Define WB_REGFILE_BYPASS_EN to forward the value being written to same-cycle reads.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              regWr_WB,
  input  logic              Wrback_WB,
  input  logic [DATA_W-1:0] ReadMemData_WB,
  input  logic [DATA_W-1:0] AluResult_WB,
  input  logic [ADDR_W-1:0] WriteReg_WB,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_we
);
  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] w_wb_data;
  logic              w_wb_we;

  // Register 0 has no storage; entries start at index 1
  logic [DATA_W-1:0] r_regs [1:NREG-1];

  wb_mux #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_wb_mux (
    .i_reg_wr    (regWr_WB),
    .i_wrback    (Wrback_WB),
    .i_mem_data  (ReadMemData_WB),
    .i_alu_result(AluResult_WB),
    .i_write_reg (WriteReg_WB),
    .o_wb_data   (w_wb_data),
    .o_wb_we     (w_wb_we)
  );

  assign wb_data = w_wb_data;
  assign wb_we   = w_wb_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_wb_we) begin
      r_regs[WriteReg_WB] <= w_wb_data;
    end
  end

  function automatic logic [DATA_W-1:0] rd_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] v;
    v = '0;
    if (addr != ADDR_W'(ZERO_REG)) begin
`ifdef WB_REGFILE_BYPASS_EN
      // w_wb_we already excludes index 0, so the zero register is never bypassed
      if (w_wb_we && (addr == WriteReg_WB)) v = w_wb_data;
      else                                  v = r_regs[addr];
`else
      v = r_regs[addr];
`endif
    end
    return v;
  endfunction

  always_comb begin
    rs_data = rd_port(rs_addr);
    rt_data = rd_port(rt_addr);
  end
endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus random traffic
// compared against an array-based register model.
module tb_wb_regfile;
  localparam int DW = 32;
  localparam int AW = 5;
`ifdef WB_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          regWr_WB;
  logic          Wrback_WB;
  logic [DW-1:0] ReadMemData_WB;
  logic [DW-1:0] AluResult_WB;
  logic [AW-1:0] WriteReg_WB;
  logic [AW-1:0] rs_addr;
  logic [AW-1:0] rt_addr;
  logic [DW-1:0] rs_data;
  logic [DW-1:0] rt_data;
  logic [DW-1:0] wb_data;
  logic          wb_we;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] model [32];

  wb_regfile #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .regWr_WB      (regWr_WB),
    .Wrback_WB     (Wrback_WB),
    .ReadMemData_WB(ReadMemData_WB),
    .AluResult_WB  (AluResult_WB),
    .WriteReg_WB   (WriteReg_WB),
    .rs_addr       (rs_addr),
    .rt_addr       (rt_addr),
    .rs_data       (rs_data),
    .rt_data       (rt_data),
    .wb_data       (wb_data),
    .wb_we         (wb_we)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge, landing mid-cycle for driving and sampling
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference: what a read port should return given the pending write this cycle
  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    logic [DW-1:0] wd;
    bit            we;
    wd = Wrback_WB ? ReadMemData_WB : AluResult_WB;
    we = regWr_WB && (WriteReg_WB != 0);
    if (a == 0) return '0;
    if (BYP && we && (a == WriteReg_WB)) return wd;
    return model[a];
  endfunction

  task automatic commit();
    if (regWr_WB && (WriteReg_WB != 0))
      model[WriteReg_WB] = Wrback_WB ? ReadMemData_WB : AluResult_WB;
  endtask

  task automatic drive(input logic we, input logic src, input logic [DW-1:0] mem,
                       input logic [DW-1:0] alu, input logic [AW-1:0] wr);
    regWr_WB = we; Wrback_WB = src; ReadMemData_WB = mem; AluResult_WB = alu; WriteReg_WB = wr;
  endtask

  initial begin
    logic [DW-1:0] wd;
    for (int i = 0; i < 32; i++) model[i] = '0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, '0, '0);
    rs_addr = '0; rt_addr = '0;
    #3;

    // Reset: all indices read zero; MEM/WB-zero inputs give zero wb outputs
    check("rst_wb_data", wb_data, 32'h0);
    check("rst_wb_we", {31'b0, wb_we}, 32'h0);
    for (int i = 0; i < 32; i++) begin
      rs_addr = AW'(i); rt_addr = AW'(31 - i);
      #1;
      check($sformatf("rst_rs[%0d]", i), rs_data, 32'h0);
      check($sformatf("rst_rt[%0d]", 31 - i), rt_data, 32'h0);
    end

    // A write attempted while reset is held must not land
    drive(1'b1, 1'b0, '0, 32'hCAFEF00D, 5'd4);
    tick();
    rs_addr = 5'd4;
    #1;
    check("rst_hold_r4", rs_data, 32'h0);
    drive(1'b0, 1'b0, '0, '0, '0);
    #1;
    rst_n = 1'b1;
    tick();

    // ALU write to r5; load data must be ignored
    drive(1'b1, 1'b0, 32'hFFFF0000, 32'h12345678, 5'd5);
    #1;
    check("alu_wb_data", wb_data, 32'h12345678);
    check("alu_wb_we", {31'b0, wb_we}, 32'h1);
    tick(); commit();
    drive(1'b0, 1'b0, '0, '0, '0);
    rs_addr = 5'd5;
    #1;
    check("alu_rd_r5", rs_data, 32'h12345678);

    // Load write to r31
    drive(1'b1, 1'b1, 32'hDEADBEEF, 32'h00000BAD, 5'd31);
    #1;
    check("ld_wb_data", wb_data, 32'hDEADBEEF);
    tick(); commit();
    drive(1'b0, 1'b0, '0, '0, '0);
    rt_addr = 5'd31;
    #1;
    check("ld_rd_r31", rt_data, 32'hDEADBEEF);

    // Zero register discards writes
    rs_addr = 5'd0;
    drive(1'b1, 1'b0, '0, 32'hFFFFFFFF, 5'd0);
    #1;
    check("z_wb_we", {31'b0, wb_we}, 32'h0);
    check("z_rd_before", rs_data, 32'h0);
    tick(); commit();
    drive(1'b0, 1'b0, '0, '0, '0);
    #1;
    check("z_rd_after", rs_data, 32'h0);

    // Same-cycle read of the write target on both ports
    drive(1'b1, 1'b0, '0, 32'h1, 5'd7);
    tick(); commit();
    drive(1'b1, 1'b0, '0, 32'h2, 5'd7);
    rs_addr = 5'd7; rt_addr = 5'd7;
    #1;
    check("same_rs", rs_data, BYP ? 32'h2 : 32'h1);
    check("same_rt", rt_data, BYP ? 32'h2 : 32'h1);
    tick(); commit();
    drive(1'b0, 1'b0, '0, '0, '0);
    #1;
    check("same_rs_next", rs_data, 32'h2);
    check("same_rt_next", rt_data, 32'h2);

    // Random traffic against the model
    for (int n = 0; n < 300; n++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom, $urandom,
            AW'($urandom_range(0, 31)));
      rs_addr = ($urandom_range(0, 3) == 0) ? WriteReg_WB : AW'($urandom_range(0, 31));
      rt_addr = ($urandom_range(0, 3) == 0) ? WriteReg_WB : AW'($urandom_range(0, 31));
      #1;
      wd = Wrback_WB ? ReadMemData_WB : AluResult_WB;
      check($sformatf("rnd%0d_wb_data", n), wb_data, wd);
      check($sformatf("rnd%0d_wb_we", n), {31'b0, wb_we},
            {31'b0, regWr_WB && (WriteReg_WB != 0)});
      check($sformatf("rnd%0d_rs[%0d]", n, rs_addr), rs_data, exp_read(rs_addr));
      check($sformatf("rnd%0d_rt[%0d]", n, rt_addr), rt_data, exp_read(rt_addr));
      tick(); commit();
    end

    // Reset mid-operation clears immediately and stays clear afterwards
    drive(1'b1, 1'b0, '0, 32'hA5A5A5A5, 5'd3);
    tick(); commit();
    drive(1'b0, 1'b0, '0, '0, '0);
    rs_addr = 5'd3; rt_addr = 5'd31;
    #1;
    check("mid_pre_r3", rs_data, 32'hA5A5A5A5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_r3", rs_data, 32'h0);
    check("mid_rst_r31", rt_data, 32'h0);
    for (int i = 0; i < 32; i++) model[i] = '0;
    #1;
    rst_n = 1'b1;
    tick();
    check("mid_post_r3", rs_data, 32'h0);
    check("mid_post_r31", rt_data, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file of the pipelined MIPS core. Consumes the MEM/WB pipeline register outputs, selects load data or ALU result, commits to one of 2^ADDR_W general registers on the rising clock edge, and serves two combinational read ports to the ID stage. Register 0 is hard-wired to zero. Optional same-cycle write-to-read bypass removes the ID/WB structural hazard.

## Interface
- DATA_W, 32, register and data width
- ADDR_W, 5, register index width; register count = 2^ADDR_W
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- regWr_WB  in  1  register write enable from MEM/WB
- Wrback_WB  in  1  write-back source select: 1 = ReadMemData_WB, 0 = AluResult_WB
- ReadMemData_WB  in  DATA_W  load data from MEM/WB
- AluResult_WB  in  DATA_W  ALU result from MEM/WB
- WriteReg_WB  in  ADDR_W  destination register index
- rs_addr  in  ADDR_W  read port A index (ID stage)
- rt_addr  in  ADDR_W  read port B index (ID stage)
- rs_data  out  DATA_W  read port A data
- rt_data  out  DATA_W  read port B data
- wb_data  out  DATA_W  selected write-back value, to forwarding unit
- wb_we  out  1  effective write: regWr_WB and WriteReg_WB != 0

## Operation
- wb_data = Wrback_WB ? ReadMemData_WB : AluResult_WB; purely combinational.
- wb_we = regWr_WB && (WriteReg_WB != 0).
- On posedge clk with wb_we=1: reg[WriteReg_WB] <= wb_data. Otherwise all registers hold.
- Writes to index 0 are discarded; reg[0] is not stored, always reads 0.
- Reads are asynchronous: rs_data = (rs_addr == 0) ? 0 : reg[rs_addr]; same for rt.
- Both read ports may address the same register, including the write target; each resolves independently.
- Reset: every register clears to 0 asynchronously on rst_n low; held at 0 while low. Reset asserted mid-write: write is lost, register reads 0 after reset.
- Inputs X/undefined when regWr_WB=0 have no effect on state.

## Timing
- Write latency: value visible on read ports from the cycle after the commit edge (without bypass) or in the same cycle (with bypass).
- Read latency: zero cycles, combinational from rs_addr/rt_addr.
- wb_data, wb_we: zero-cycle combinational from MEM/WB inputs.
- Reset values: rs_data = 0, rt_data = 0 (all registers 0); wb_data and wb_we follow inputs (MEM/WB itself resets to 0, giving wb_data = 0, wb_we = 0).
- No handshake; one write per cycle maximum, no stalls generated.

## Configuration
- WB_REGFILE_BYPASS_EN defined: if wb_we=1 and rs_addr == WriteReg_WB, rs_data = wb_data in the same cycle; likewise rt. Index 0 never bypassed.
- Undefined: read ports return the stored value only; a read of the register being written returns the old value until after the clock edge. Hazard unit must then stall one extra cycle for WB-to-ID dependencies.

## Structure
- Shared package: DATA_W/ADDR_W defaults, ZERO_REG index constant, Wrback encoding constants (WB_SRC_ALU = 0, WB_SRC_MEM = 1).
- One sub-module: wb_mux (source select plus wb_we generation), reused by the forwarding unit's model.
- Storage: flop array of 2^ADDR_W - 1 entries, async-reset.

## Test plan
- Reset: hold rst_n low, read all 32 indices -> every rs_data/rt_data = 0x00000000.
- ALU write: regWr_WB=1, Wrback_WB=0, AluResult_WB=0x12345678, WriteReg_WB=5; next cycle rs_addr=5 -> rs_data=0x12345678; ReadMemData_WB value ignored.
- Load write: regWr_WB=1, Wrback_WB=1, ReadMemData_WB=0xDEADBEEF, WriteReg_WB=31; then rt_addr=31 -> 0xDEADBEEF, wb_data=0xDEADBEEF during write cycle.
- Zero register: write 0xFFFFFFFF to index 0 -> wb_we=0, rs_addr=0 reads 0 before and after.
- Same-cycle read of write target: reg[7]=0x1, write 0x2 to 7 while rs_addr=rt_addr=7 -> with WB_REGFILE_BYPASS_EN both read 0x2 that cycle; without, both read 0x1, then 0x2 next cycle.
- Reset mid-operation: write 0xA5A5A5A5 to reg 3, assert rst_n low between edges -> rs_data(3) drops to 0 immediately; after release, regWr_WB=0 holds reg 3 at 0.
